// File: rtl/st_frontend_ctrl_block_if.sv
// st_frontend_ctrl_block_if
//   Token-stream and control bundle between the network input port / store
//   sequencer (master) and the store-side front-end block controller (slave).
//   Handshake: a word transfers on a rising clock edge when I_Valid and
//   O_Ready are both high. O_Ready never depends on I_Valid, so a source may
//   hold I_Valid and its word for any number of cycles until O_Ready is high.
//   I_* : requests and word fields from the source side.
//   O_* : readiness, word classification, store strobe and end-of-block pulses.
interface st_frontend_ctrl_block_if;
  logic       I_Event_Store;
  logic       I_Bypass;
  logic [7:0] I_Length;
  logic       I_Valid;
  logic       I_Nack;
  logic [7:0] I_Attrib_Length;
  logic       I_Attrib_Term;
  logic       I_Abort;
  logic       O_Ready;
  logic       O_is_MyID;
  logic       O_is_IDWord;
  logic       O_is_AttributeWord;
  logic       O_is_BodyWord;
  logic       O_Store;
  logic       O_is_End_Block;
  logic       O_is_End_Term_Block;

  modport master (
    output I_Event_Store, I_Bypass, I_Length, I_Valid, I_Nack,
           I_Attrib_Length, I_Attrib_Term, I_Abort,
    input  O_Ready, O_is_MyID, O_is_IDWord, O_is_AttributeWord,
           O_is_BodyWord, O_Store, O_is_End_Block, O_is_End_Term_Block
  );

  modport slave (
    input  I_Event_Store, I_Bypass, I_Length, I_Valid, I_Nack,
           I_Attrib_Length, I_Attrib_Term, I_Abort,
    output O_Ready, O_is_MyID, O_is_IDWord, O_is_AttributeWord,
           O_is_BodyWord, O_Store, O_is_End_Block, O_is_End_Term_Block
  );
endinterface

// File: rtl/st_frontend_ctrl_block.sv
// st_frontend_ctrl_block
//   Frames the incoming store token stream into MyID, three ID words, an
//   attribute word and a body whose length comes from the attribute word
//   (or from I_Length when bypassing the header). Attribute and body words
//   are written to memory (O_Store); MyID/ID words are consumed only.
// Ports
//   clock     : system clock
//   reset     : asynchronous, active-high reset
//   bus       : token stream / control bundle (slave side)
//   dbg_state : registered FSM state for observation
// Parameter
//   EXTERNAL  : 1 = a non-terminal, non-bypass block chains back to the
//               attribute word; 0 = always return to INIT after a body.
module st_frontend_ctrl_block #(
  parameter bit EXTERNAL = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  st_frontend_ctrl_block_if.slave     bus,
  output logic [2:0]                  dbg_state
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_MYID   = 3'd1;
  localparam logic [2:0] S_ID     = 3'd2;
  localparam logic [2:0] S_ATTRIB = 3'd3;
  localparam logic [2:0] S_BODY   = 3'd4;

  logic [2:0] state;
  logic [1:0] r_cnt_id;
  logic [8:0] r_count;     // words left in the body, 9 bits so 8'hFF+1 fits
  logic       r_term;
  logic       r_bypass;    // current body was entered through bypass
  logic       r_end;
  logic       r_end_term;
  logic       accept;

  assign bus.O_Ready            = (state != S_INIT) & ~bus.I_Nack;
  assign accept                 = bus.I_Valid & bus.O_Ready;
  assign bus.O_is_MyID          = (state == S_MYID);
  assign bus.O_is_IDWord        = (state == S_ID);
  assign bus.O_is_AttributeWord = (state == S_ATTRIB);
  assign bus.O_is_BodyWord      = (state == S_BODY);
  assign bus.O_Store            = accept & ((state == S_ATTRIB) | (state == S_BODY));
  assign bus.O_is_End_Block     = r_end;
  assign bus.O_is_End_Term_Block = r_end_term;
  assign dbg_state              = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      r_cnt_id   <= 2'd0;
      r_count    <= 9'd0;
      r_term     <= 1'b0;
      r_bypass   <= 1'b0;
      r_end      <= 1'b0;
      r_end_term <= 1'b0;
    end else if (bus.I_Abort) begin
      // Abort wins over everything, including an end pulse that would
      // otherwise be raised by a last body word accepted this cycle.
      state      <= S_INIT;
      r_cnt_id   <= 2'd0;
      r_count    <= 9'd0;
      r_term     <= 1'b0;
      r_bypass   <= 1'b0;
      r_end      <= 1'b0;
      r_end_term <= 1'b0;
    end else begin
      r_end      <= 1'b0;
      r_end_term <= 1'b0;
      case (state)
        S_INIT: begin
          if (bus.I_Event_Store) begin
            if (bus.I_Bypass) begin
              state    <= S_BODY;
              r_count  <= {1'b0, bus.I_Length} + 9'd1;
              r_term   <= 1'b1;
              r_bypass <= 1'b1;
            end else begin
              state <= S_MYID;
            end
          end
        end
        S_MYID: begin
          if (accept) begin
            state    <= S_ID;
            r_cnt_id <= 2'd1;
          end
        end
        S_ID: begin
          // Counter runs 1,2,3: the accept seen at 3 is the third ID word.
          if (accept) begin
            if (r_cnt_id == 2'd3) begin
              state    <= S_ATTRIB;
              r_cnt_id <= 2'd0;
            end else begin
              r_cnt_id <= r_cnt_id + 2'd1;
            end
          end
        end
        S_ATTRIB: begin
          if (accept) begin
            state    <= S_BODY;
            r_count  <= {1'b0, bus.I_Attrib_Length} + 9'd1;
            r_term   <= bus.I_Attrib_Term;
            r_bypass <= 1'b0;
          end
        end
        S_BODY: begin
          if (accept) begin
            if (r_count <= 9'd1) begin
              r_count    <= 9'd0;
              r_end      <= 1'b1;
              r_end_term <= r_term;
              if (r_term || !EXTERNAL || r_bypass) begin
                state <= S_INIT;
              end else begin
                state <= S_ATTRIB;
              end
            end else begin
              r_count <= r_count - 9'd1;
            end
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
